spi_slave_buffered: RTL

Parametrised next-generation SPI slave with independent TX and RX FIFOs, all four SPI modes, and sticky error flags. Serial pins are oversampled in the `clk` domain; no logic runs on `sck`. Sits between an external SPI master and on-chip logic such as register files or LED drivers, and replaces the single-buffer, mode-0-only slave. Continuous multi-word frames are supported without host stalls, provided the TX FIFO is fed.

---
 rtl/spi_slave_buffered.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_buffered.sv
// SPI slave with TX/RX FIFOs, all four SPI modes and sticky error flags.
// Pins are oversampled in the clk domain; sck never clocks any logic.
// Ports: clk, reset (async, active-low); cs/sck/mosi/miso serial pins;
//   busy (frame in progress); tx_data/tx_write/tx_full/tx_level (TX side);
//   rx_data/rx_read/rx_empty/rx_level (RX side, first-word-fall-through);
//   rx_overflow/tx_underrun/frame_error sticky flags, cleared by clear_flags.
// Build option: define SPI_MISO_TRISTATE_EN to float miso outside a frame.
module spi_slave_buffered #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TX_DEPTH = 16,
   parameter int unsigned RX_DEPTH = 256,
   parameter bit CPOL = 1'b0,
   parameter bit CPHA = 1'b0,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD = '0
) (
   input  logic clk,
   input  logic reset,
   input  logic cs,
   input  logic sck,
   input  logic mosi,
   output logic miso,
   output logic busy,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic tx_write,
   output logic tx_full,
   output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
   output logic [DATA_WIDTH-1:0] rx_data,
   input  logic rx_read,
   output logic rx_empty,
   output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
   output logic rx_overflow,
   output logic tx_underrun,
   output logic frame_error,
   input  logic clear_flags
);

   localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned TPW = $clog2(TX_DEPTH);
   localparam int unsigned TLW = $clog2(TX_DEPTH + 1);
   localparam int unsigned RPW = $clog2(RX_DEPTH);
   localparam int unsigned RLW = $clog2(RX_DEPTH + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   // [0],[1] synchroniser, [2] previous synced value for edge detect
   logic [2:0] cs_q;
   logic [2:0] sck_q;
   logic [1:0] mosi_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_q <= '1;
         sck_q <= {3{CPOL}};
         mosi_q <= '0;
      end else begin
         cs_q <= {cs_q[1:0], cs};
         sck_q <= {sck_q[1:0], sck};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   logic cs_fall, cs_rise, lead, trail, sample, shift;
   assign cs_fall = cs_q[2] & ~cs_q[1];
   assign cs_rise = ~cs_q[2] & cs_q[1];
   assign lead = (sck_q[2] == CPOL) & (sck_q[1] != CPOL);
   assign trail = (sck_q[2] != CPOL) & (sck_q[1] == CPOL);
   assign sample = CPHA ? trail : lead;
   assign shift = CPHA ? lead : trail;

   logic [0:0] state;
   logic [CW-1:0] cnt;
   logic [DATA_WIDTH-1:0] rx_sh, tx_sh;
   logic miso_q;
   logic pend;
   logic complete, load;

   assign complete = (state == XFER) && (cnt == CW'(DATA_WIDTH));
   assign load = ((state == IDLE) && cs_fall) || complete;
   assign busy = (state == XFER);

   // TX FIFO
   logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
   logic [TPW-1:0] tx_wp, tx_rp;
   logic tx_empty, tx_pop, tx_push;
   logic [DATA_WIDTH-1:0] next_word;

   assign tx_empty = (tx_level == '0);
   assign tx_full = (tx_level == TLW'(TX_DEPTH));
   assign tx_pop = load & ~tx_empty;
   // a pop in the same cycle frees the slot for a write to a full FIFO
   assign tx_push = tx_write & (~tx_full | tx_pop);
   assign next_word = tx_empty ? IDLE_WORD : tx_mem[tx_rp];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wp <= '0;
         tx_rp <= '0;
         tx_level <= '0;
      end else begin
         tx_wp <= tx_wp + TPW'(tx_push);
         tx_rp <= tx_rp + TPW'(tx_pop);
         tx_level <= tx_level + TLW'(tx_push) - TLW'(tx_pop);
      end
   end

   // RX FIFO
   logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
   logic [RPW-1:0] rx_wp, rx_rp;
   logic rx_full, rx_pop, rx_put;

   assign rx_empty = (rx_level == '0);
   assign rx_full = (rx_level == RLW'(RX_DEPTH));
   assign rx_pop = rx_read & ~rx_empty;
   assign rx_put = complete & (~rx_full | rx_read);
   assign rx_data = rx_mem[rx_rp];

   always_ff @(posedge clk) begin
      if (rx_put) rx_mem[rx_wp] <= rx_sh;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wp <= '0;
         rx_rp <= '0;
         rx_level <= '0;
      end else begin
         rx_wp <= rx_wp + RPW'(rx_put);
         rx_rp <= rx_rp + RPW'(rx_pop);
         rx_level <= rx_level + RLW'(rx_put) - RLW'(rx_pop);
      end
   end

   // Underrun is flagged when an IDLE_WORD load is actually exchanged,
   // so the reload after the last word of a frame raises no flag.
   logic ovf_set, fe_set, ur_set;
   assign ovf_set = complete & rx_full & ~rx_read;
   assign fe_set = (state == XFER) & cs_rise & (cnt != '0) & ~complete;
   assign ur_set = (state == XFER) & sample & pend & (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_overflow <= 1'b0;
         tx_underrun <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         rx_overflow <= ovf_set | (rx_overflow & ~clear_flags);
         tx_underrun <= ur_set | (tx_underrun & ~clear_flags);
         frame_error <= fe_set | (frame_error & ~clear_flags);
      end
   end

   // CPHA=0 presents the MSB at load; CPHA=1 presents it on the first
   // leading edge, so the full word stays in tx_sh for that mode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         rx_sh <= '0;
         tx_sh <= '0;
         miso_q <= 1'b0;
         pend <= 1'b0;
      end else begin
         if (load) begin
            tx_sh <= CPHA ? next_word : next_word << 1;
            miso_q <= next_word[DATA_WIDTH-1];
            pend <= tx_empty;
         end
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (cs_fall) state <= XFER;
            end
            XFER: begin
               if (complete) begin
                  cnt <= '0;
               end else begin
                  if (sample) begin
                     rx_sh <= {rx_sh[DATA_WIDTH-2:0], mosi_q[1]};
                     cnt <= cnt + CW'(1);
                  end
                  if (shift && (CPHA || cnt != '0)) begin
                     miso_q <= tx_sh[DATA_WIDTH-1];
                     tx_sh <= tx_sh << 1;
                  end
               end
               if (cs_rise) begin
                  state <= IDLE;
                  cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_MISO_TRISTATE_EN
   assign miso = (state == XFER) ? miso_q : 1'bz;
`else
   assign miso = (state == XFER) & miso_q;
`endif

endmodule
